// File: rtl/vga_text_console.sv
// Character-stream front end for the VGA text controller: tracks the cursor, emits one-cycle writes, scrolls via the row-offset register.
// Optional build macro VGA_TEXT_CONSOLE_CLEAR_ON_RESET_EN clears the whole screen after reset.
module vga_text_console #(
  parameter int          COLS        = 80,
  parameter int          ROWS        = 30,
  parameter logic [31:0] OFFSET_ADDR = 32'h0000_1000
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic        write_op,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam int AW = $clog2(COLS * ROWS);
  localparam logic [AW-1:0] LAST_BASE = AW'(COLS * (ROWS - 1));

  typedef enum logic [2:0] {IDLE, WRITE, SCROLL, CLEAR, INIT} state_t;

`ifdef VGA_TEXT_CONSOLE_CLEAR_ON_RESET_EN
  localparam state_t RST_STATE = INIT;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  // Advance a row base address by one row, wrapping the last row back to 0.
  function automatic logic [AW-1:0] rb_step(input logic [AW-1:0] rb);
    return (rb == LAST_BASE) ? '0 : rb + AW'(COLS);
  endfunction

  state_t        state, nxt_state;
  logic [4:0]    top_row, nxt_top;
  logic [AW-1:0] row_base, nxt_rb;
  logic [AW-1:0] clr_last, nxt_last;
  logic          pend, nxt_pend;
  logic [6:0]    nxt_col;
  logic [4:0]    nxt_row;
  logic          nxt_wr;
  logic [31:0]   nxt_addr, nxt_data;
  logic          do_scroll;
  logic [AW-1:0] rb_adv;

  assign rb_adv     = rb_step(row_base);
  assign char_ready = (state == IDLE);
  assign busy       = ~char_ready;

  always_comb begin
    nxt_state = state;
    nxt_col   = cursor_col;
    nxt_row   = cursor_row;
    nxt_top   = top_row;
    nxt_rb    = row_base;
    nxt_last  = clr_last;
    nxt_pend  = pend;
    nxt_wr    = 1'b0;
    nxt_addr  = '0;
    nxt_data  = '0;
    do_scroll = 1'b0;
    case (state)
      IDLE: begin
        if (char_valid) begin
          if (char_data >= 8'h20 && char_data <= 8'h7E) begin
            nxt_wr    = 1'b1;
            nxt_addr  = 32'(row_base) + 32'(cursor_col);
            nxt_data  = {24'h0, char_data};
            nxt_state = WRITE;
            nxt_pend  = 1'b0;
            if (cursor_col == 7'(COLS - 1)) begin
              nxt_col = '0;
              if (cursor_row == 5'(ROWS - 1)) begin
                nxt_pend = 1'b1;
              end else begin
                nxt_row = cursor_row + 5'd1;
                nxt_rb  = rb_adv;
              end
            end else begin
              nxt_col = cursor_col + 7'd1;
            end
          end else if (char_data == 8'h0A) begin
            nxt_col = '0;
            if (cursor_row == 5'(ROWS - 1)) begin
              do_scroll = 1'b1;
            end else begin
              nxt_row = cursor_row + 5'd1;
              nxt_rb  = rb_adv;
            end
          end else if (char_data == 8'h0D) begin
            nxt_col = '0;
          end else if (char_data == 8'h08 && cursor_col != '0) begin
            nxt_col   = cursor_col - 7'd1;
            nxt_wr    = 1'b1;
            nxt_addr  = 32'(row_base) + 32'(cursor_col - 7'd1);
            nxt_data  = 32'h20;
            nxt_state = WRITE;
            nxt_pend  = 1'b0;
          end
        end
      end
      WRITE: begin
        if (pend) do_scroll = 1'b1;
        else      nxt_state = IDLE;
      end
      SCROLL: begin
        // row_base already points at the newly exposed row
        nxt_wr    = 1'b1;
        nxt_addr  = 32'(row_base);
        nxt_data  = 32'h20;
        nxt_state = CLEAR;
      end
      CLEAR: begin
        if (bus_addr[AW-1:0] == clr_last) begin
          nxt_state = IDLE;
        end else begin
          nxt_wr   = 1'b1;
          nxt_addr = bus_addr + 32'd1;
          nxt_data = 32'h20;
        end
      end
      INIT: begin
        // Reuse SCROLL/CLEAR to wipe the whole buffer starting at address 0
        nxt_wr    = 1'b1;
        nxt_addr  = OFFSET_ADDR;
        nxt_data  = '0;
        nxt_last  = AW'(COLS * ROWS - 1);
        nxt_state = SCROLL;
      end
      default: nxt_state = IDLE;
    endcase
    if (do_scroll) begin
      nxt_top   = (top_row == 5'(ROWS - 1)) ? '0 : top_row + 5'd1;
      nxt_rb    = rb_adv;
      nxt_last  = rb_adv + AW'(COLS - 1);
      nxt_pend  = 1'b0;
      nxt_wr    = 1'b1;
      nxt_addr  = OFFSET_ADDR;
      nxt_data  = 32'(nxt_top);
      nxt_state = SCROLL;
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RST_STATE;
      cursor_col <= '0;
      cursor_row <= '0;
      top_row    <= '0;
      row_base   <= '0;
      clr_last   <= '0;
      pend       <= 1'b0;
      write_op   <= 1'b0;
      bus_addr   <= '0;
      bus_data   <= '0;
    end else begin
      state      <= nxt_state;
      cursor_col <= nxt_col;
      cursor_row <= nxt_row;
      top_row    <= nxt_top;
      row_base   <= nxt_rb;
      clr_last   <= nxt_last;
      pend       <= nxt_pend;
      write_op   <= nxt_wr;
      bus_addr   <= nxt_addr;
      bus_data   <= nxt_data;
    end
  end

endmodule

// File: tb/tb_vga_text_console.sv
// Directed bench for vga_text_console (default build): cursor handling, line wrap, scrolling, wrap of top_row, async reset.
module tb_vga_text_console;

  localparam int          COLS = 80;
  localparam int          ROWS = 30;
  localparam logic [31:0] OFS  = 32'h0000_1000;

  logic        clk_50M = 1'b0;
  logic        rst_n = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready, write_op, busy;
  logic [31:0] bus_addr, bus_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  int total = 0;
  int bad = 0;
  int zv = 0;
  logic [31:0] aq[$];
  logic [31:0] dq[$];

  vga_text_console #(.COLS(COLS), .ROWS(ROWS), .OFFSET_ADDR(OFS)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .write_op(write_op), .bus_addr(bus_addr), .bus_data(bus_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  always #10 clk_50M = ~clk_50M;

  always @(negedge clk_50M) begin
    if (rst_n) begin
      if (write_op) begin
        aq.push_back(bus_addr);
        dq.push_back(bus_data);
      end else if (bus_addr !== 32'h0 || bus_data !== 32'h0) begin
        zv++;
      end
    end
  end

  task automatic wait_idle(output int n);
    n = 0;
    while (char_ready !== 1'b1 && n < 5000) begin
      n++;
      @(posedge clk_50M); #1;
    end
    if (n >= 5000) begin
      total++; bad++;
      $display("FAIL wait_idle: got busy after %0d cycles, want ready", n);
    end
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    wait_idle(n);
    char_data = c;
    char_valid = 1'b1;
    @(posedge clk_50M); #1;
    char_valid = 1'b0;
    char_data = 8'h00;
  endtask

  task automatic do_reset;
    char_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk_50M);
    @(negedge clk_50M);
    rst_n = 1'b1;
    @(posedge clk_50M); #1;
    aq.delete(); dq.delete();
  endtask

  task automatic test_reset;
    do_reset();
    total++; if (write_op !== 1'b0) begin bad++; $display("FAIL rst_write_op: got %0h want 0", write_op); end
    total++; if (bus_addr !== 32'h0) begin bad++; $display("FAIL rst_bus_addr: got %0h want 0", bus_addr); end
    total++; if (bus_data !== 32'h0) begin bad++; $display("FAIL rst_bus_data: got %0h want 0", bus_data); end
    total++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin bad++; $display("FAIL rst_cursor: got (%0d,%0d) want (0,0)", cursor_col, cursor_row); end
    total++; if (char_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_ready: got ready=%0b busy=%0b want 1/0", char_ready, busy); end
  endtask

  task automatic test_print_a;
    do_reset();
    send(8'h41);
    total++; if (write_op !== 1'b1 || bus_addr !== 32'd0 || bus_data !== 32'h41) begin bad++; $display("FAIL a_write: got op=%0b addr=%0h data=%0h want 1/0/41", write_op, bus_addr, bus_data); end
    total++; if (cursor_col !== 7'd1) begin bad++; $display("FAIL a_col: got %0d want 1", cursor_col); end
    total++; if (char_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL a_busy: got ready=%0b busy=%0b want 0/1", char_ready, busy); end
    @(posedge clk_50M); #1;
    total++; if (char_ready !== 1'b1) begin bad++; $display("FAIL a_ready_back: got %0b want 1", char_ready); end
    total++; if (write_op !== 1'b0 || bus_addr !== 32'h0 || bus_data !== 32'h0) begin bad++; $display("FAIL a_idle_bus: got op=%0b addr=%0h data=%0h want 0/0/0", write_op, bus_addr, bus_data); end
  endtask

  task automatic test_line_wrap;
    int n;
    do_reset();
    for (int i = 0; i < COLS; i++) send(8'h78);
    wait_idle(n);
    total++; if (aq.size() !== COLS) begin bad++; $display("FAIL wrap_count: got %0d want %0d", aq.size(), COLS); end
    if (aq.size() >= COLS) begin
      for (int i = 0; i < COLS; i++) begin
        total++;
        if (aq[i] !== 32'(i) || dq[i] !== 32'h78) begin bad++; $display("FAIL wrap_wr%0d: got %0h/%0h want %0h/78", i, aq[i], dq[i], i); end
      end
    end
    total++; if (cursor_col !== 7'd0 || cursor_row !== 5'd1) begin bad++; $display("FAIL wrap_cursor: got (%0d,%0d) want (0,1)", cursor_col, cursor_row); end
    aq.delete(); dq.delete();
    send(8'h79);
    wait_idle(n);
    total++; if (aq.size() !== 1 || aq[0] !== 32'd80 || dq[0] !== 32'h79) begin bad++; $display("FAIL wrap_y: got n=%0d addr=%0h want 1 write at 50", aq.size(), (aq.size() > 0) ? aq[0] : 32'hx); end
  endtask

  task automatic test_cr_bs;
    int n;
    do_reset();
    for (int i = 0; i < 3; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h61);
    wait_idle(n);
    total++; if (cursor_col !== 7'd5 || cursor_row !== 5'd3) begin bad++; $display("FAIL crbs_pos: got (%0d,%0d) want (5,3)", cursor_col, cursor_row); end
    aq.delete(); dq.delete();
    send(8'h0D); send(8'h08); send(8'h01); send(8'h7F);
    wait_idle(n);
    total++; if (aq.size() !== 0) begin bad++; $display("FAIL crbs_nowrite: got %0d writes want 0", aq.size()); end
    total++; if (cursor_col !== 7'd0 || cursor_row !== 5'd3) begin bad++; $display("FAIL crbs_cursor: got (%0d,%0d) want (0,3)", cursor_col, cursor_row); end
    send(8'h7A);
    wait_idle(n);
    total++; if (aq.size() !== 1 || aq[0] !== 32'd240 || dq[0] !== 32'h7A) begin bad++; $display("FAIL crbs_z: got n=%0d want write 7a at f0", aq.size()); end
    send(8'h08);
    wait_idle(n);
    total++; if (aq.size() !== 2 || aq[1] !== 32'd240 || dq[1] !== 32'h20) begin bad++; $display("FAIL crbs_bs: got n=%0d want space at f0", aq.size()); end
    total++; if (cursor_col !== 7'd0) begin bad++; $display("FAIL crbs_bs_col: got %0d want 0", cursor_col); end
  endtask

  task automatic test_scroll;
    int n;
    do_reset();
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    wait_idle(n);
    aq.delete(); dq.delete();
    send(8'h0A);
    wait_idle(n);
    total++; if (n !== COLS + 1) begin bad++; $display("FAIL scroll_busy: got %0d want %0d", n, COLS + 1); end
    total++; if (aq.size() !== COLS + 1) begin bad++; $display("FAIL scroll_count: got %0d want %0d", aq.size(), COLS + 1); end
    if (aq.size() >= COLS + 1) begin
      total++; if (aq[0] !== OFS || dq[0] !== 32'd1) begin bad++; $display("FAIL scroll_ofs: got %0h/%0h want 1000/1", aq[0], dq[0]); end
      for (int i = 0; i < COLS; i++) begin
        total++;
        if (aq[i+1] !== 32'(i) || dq[i+1] !== 32'h20) begin bad++; $display("FAIL scroll_clr%0d: got %0h/%0h want %0h/20", i, aq[i+1], dq[i+1], i); end
      end
    end
    total++; if (cursor_col !== 7'd0 || cursor_row !== 5'd29) begin bad++; $display("FAIL scroll_cursor: got (%0d,%0d) want (0,29)", cursor_col, cursor_row); end
    // printable in the last cell of the last row: char write, then scroll and clear
    for (int i = 0; i < COLS - 1; i++) send(8'h78);
    wait_idle(n);
    aq.delete(); dq.delete();
    send(8'h78);
    wait_idle(n);
    total++; if (n !== COLS + 2) begin bad++; $display("FAIL lastcell_busy: got %0d want %0d", n, COLS + 2); end
    total++; if (aq.size() !== COLS + 2) begin bad++; $display("FAIL lastcell_count: got %0d want %0d", aq.size(), COLS + 2); end
    if (aq.size() >= COLS + 2) begin
      total++; if (aq[0] !== 32'd79 || dq[0] !== 32'h78) begin bad++; $display("FAIL lastcell_char: got %0h/%0h want 4f/78", aq[0], dq[0]); end
      total++; if (aq[1] !== OFS || dq[1] !== 32'd2) begin bad++; $display("FAIL lastcell_ofs: got %0h/%0h want 1000/2", aq[1], dq[1]); end
      total++; if (aq[2] !== 32'd80 || aq[COLS+1] !== 32'd159 || dq[COLS+1] !== 32'h20) begin bad++; $display("FAIL lastcell_clr: got %0h..%0h want 50..9f", aq[2], aq[COLS+1]); end
    end
    total++; if (cursor_col !== 7'd0 || cursor_row !== 5'd29) begin bad++; $display("FAIL lastcell_cursor: got (%0d,%0d) want (0,29)", cursor_col, cursor_row); end
  endtask

  task automatic test_wrap_and_reset;
    int n;
    do_reset();
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    wait_idle(n);
    aq.delete(); dq.delete();
    send(8'h0A);
    wait_idle(n);
    total++; if (aq.size() !== COLS + 1) begin bad++; $display("FAIL topwrap_count: got %0d want %0d", aq.size(), COLS + 1); end
    if (aq.size() >= COLS + 1) begin
      total++; if (aq[0] !== OFS || dq[0] !== 32'd0) begin bad++; $display("FAIL topwrap_ofs: got %0h/%0h want 1000/0", aq[0], dq[0]); end
      total++; if (aq[1] !== 32'd2320 || aq[COLS] !== 32'd2399) begin bad++; $display("FAIL topwrap_clr: got %0h..%0h want 910..95f", aq[1], aq[COLS]); end
    end
    send(8'h0A);
    repeat (10) @(posedge clk_50M);
    #3;
    total++; if (write_op !== 1'b1) begin bad++; $display("FAIL midclear_active: got %0b want 1", write_op); end
    rst_n = 1'b0;
    #1;
    total++; if (write_op !== 1'b0 || bus_addr !== 32'h0 || bus_data !== 32'h0) begin bad++; $display("FAIL async_rst_bus: got op=%0b addr=%0h data=%0h want 0/0/0", write_op, bus_addr, bus_data); end
    total++; if (cursor_col !== 7'd0 || cursor_row !== 5'd0 || char_ready !== 1'b1) begin bad++; $display("FAIL async_rst_state: got (%0d,%0d) ready=%0b want (0,0) 1", cursor_col, cursor_row, char_ready); end
    @(negedge clk_50M);
    rst_n = 1'b1;
    @(posedge clk_50M); #1;
    aq.delete(); dq.delete();
    send(8'h42);
    wait_idle(n);
    total++; if (aq.size() !== 1 || aq[0] !== 32'd0 || dq[0] !== 32'h42) begin bad++; $display("FAIL post_rst_char: got n=%0d want write 42 at 0", aq.size()); end
  endtask

  task automatic test_idle_zero;
    total++; if (zv !== 0) begin bad++; $display("FAIL idle_bus_zero: got %0d nonzero idle cycles want 0", zv); end
  endtask

  initial begin
    test_reset();
    test_print_a();
    test_line_wrap();
    test_cr_bs();
    test_scroll();
    test_wrap_and_reset();
    test_idle_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
